// File: rtl/serdesphy_i2c_slave.sv
// serdesphy_i2c_slave
// I2C target front-end for the SerDes PHY control plane. Oversamples the raw
// SCL/SDA pins on the system clock, decodes START/STOP and bytes, and drives
// the single-cycle CSR register interface through an auto-incrementing
// register pointer.
//
// Ports:
//   clk          system clock (all logic on rising edge)
//   rst          synchronous active-high reset
//   scl_in       raw SCL pin level (asynchronous)
//   sda_in       raw SDA pin level (asynchronous)
//   sda_oe       1 pulls SDA low, 0 releases it (open-drain pad is external)
//   reg_addr     register pointer
//   reg_wdata    write data byte, held until the next write
//   reg_write_en one-cycle write strobe
//   reg_read_en  one-cycle read strobe
//   reg_rdata    read data, valid the cycle after reg_read_en
//   busy         high from a detected START to a detected STOP
module serdesphy_i2c_slave #(
   parameter logic [6:0] I2C_ADDR = 7'h42
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_write_en,
   output logic       reg_read_en,
   input  logic [7:0] reg_rdata,
   output logic       busy
);

   typedef enum logic [3:0] {
      ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
      ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_IGNORE
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] scl_sync_q, scl_sync_d;
   logic [1:0] sda_sync_q, sda_sync_d;
   logic       scl_hist_q, scl_hist_d;
   logic       sda_hist_q, sda_hist_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] rx_q, rx_d;
   logic [7:0] tx_q, tx_d;
   logic       rw_q, rw_d;
   logic [7:0] ptr_q, ptr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       we_q, we_d;
   logic       re_q, re_d;
   logic       cap_q, cap_d;      // reg_rdata is valid this cycle (one after re_q)
   logic       first_q, first_d;  // next RDATA fall drives the MSB of a fresh byte
   logic       sda_oe_q, sda_oe_d;
   logic       busy_q, busy_d;

   logic       scl_s, sda_s;
   logic       scl_rise, scl_fall, start_det, stop_det;
   logic [7:0] rx_byte;

   assign scl_s     = scl_sync_q[1];
   assign sda_s     = sda_sync_q[1];
   assign scl_rise  =  scl_s & ~scl_hist_q;
   assign scl_fall  = ~scl_s &  scl_hist_q;
   assign start_det =  scl_s &  sda_hist_q & ~sda_s;
   assign stop_det  =  scl_s & ~sda_hist_q &  sda_s;
   assign rx_byte   = {rx_q[6:0], sda_s};

   always_comb begin
      scl_sync_d = {scl_sync_q[0], scl_in};
      sda_sync_d = {sda_sync_q[0], sda_in};
      scl_hist_d = scl_s;
      sda_hist_d = sda_s;
      state_d    = state_q;
      cnt_d      = cnt_q;
      rx_d       = rx_q;
      tx_d       = tx_q;
      rw_d       = rw_q;
      ptr_d      = ptr_q;
      wdata_d    = wdata_q;
      we_d       = 1'b0;
      re_d       = 1'b0;
      cap_d      = re_q;
      first_d    = first_q;
      sda_oe_d   = sda_oe_q;
      busy_d     = busy_q;

      // Pointer advances the cycle after a write strobe, and together with
      // the TX capture two cycles after a read strobe.
      if (we_q) begin
         ptr_d = ptr_q + 8'd1;
      end
      if (cap_q) begin
         tx_d  = reg_rdata;
         ptr_d = ptr_q + 8'd1;
      end

      if (start_det) begin
         state_d  = ST_ADDR;
         cnt_d    = 3'd0;
         busy_d   = 1'b1;
         sda_oe_d = 1'b0;
         first_d  = 1'b0;
      end else if (stop_det) begin
         state_d  = ST_IDLE;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         case (state_q)
            ST_ADDR, ST_PTR, ST_WDATA: begin
               if (scl_rise) begin
                  rx_d  = rx_byte;
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     if (state_q == ST_ADDR) begin
                        if (rx_byte[7:1] == I2C_ADDR) begin
                           state_d = ST_ADDR_ACK;
                           rw_d    = rx_byte[0];
                           re_d    = rx_byte[0];
                        end else begin
                           state_d = ST_IGNORE;
                        end
                     end else if (state_q == ST_PTR) begin
                        ptr_d   = rx_byte;
                        state_d = ST_PTR_ACK;
                     end else begin
                        we_d    = 1'b1;
                        wdata_d = rx_byte;
                        state_d = ST_WDATA_ACK;
                     end
                  end
               end
            end
            // First fall after the byte asserts the ACK; sda_oe_q tells the
            // two fall events of the ACK bit apart.
            ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else begin
                     cnt_d    = 3'd0;
                     sda_oe_d = 1'b0;
                     if (state_q == ST_ADDR_ACK && rw_q) begin
                        sda_oe_d = ~tx_q[7];
                        tx_d     = {tx_q[6:0], 1'b0};
                        cnt_d    = 3'd1;
                        state_d  = ST_RDATA;
                     end else if (state_q == ST_ADDR_ACK) begin
                        state_d = ST_PTR;
                     end else begin
                        state_d = ST_WDATA;
                     end
                  end
               end
            end
            // cnt_q counts bits already driven; wrapping to 0 means all 8 are out.
            ST_RDATA: begin
               if (scl_fall) begin
                  if (first_q || cnt_q != 3'd0) begin
                     sda_oe_d = ~tx_q[7];
                     tx_d     = {tx_q[6:0], 1'b0};
                     cnt_d    = cnt_q + 3'd1;
                     first_d  = 1'b0;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = ST_RDATA_ACK;
                  end
               end
            end
            ST_RDATA_ACK: begin
               if (scl_rise) begin
                  if (!sda_s) begin
                     re_d    = 1'b1;
                     cnt_d   = 3'd0;
                     first_d = 1'b1;
                     state_d = ST_RDATA;
                  end else begin
                     state_d = ST_IGNORE;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_hist_q <= 1'b1;
         sda_hist_q <= 1'b1;
         cnt_q      <= 3'd0;
         rx_q       <= 8'h00;
         tx_q       <= 8'h00;
         rw_q       <= 1'b0;
         ptr_q      <= 8'h00;
         wdata_q    <= 8'h00;
         we_q       <= 1'b0;
         re_q       <= 1'b0;
         cap_q      <= 1'b0;
         first_q    <= 1'b0;
         sda_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_hist_q <= scl_hist_d;
         sda_hist_q <= sda_hist_d;
         cnt_q      <= cnt_d;
         rx_q       <= rx_d;
         tx_q       <= tx_d;
         rw_q       <= rw_d;
         ptr_q      <= ptr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         re_q       <= re_d;
         cap_q      <= cap_d;
         first_q    <= first_d;
         sda_oe_q   <= sda_oe_d;
         busy_q     <= busy_d;
      end
   end

   assign sda_oe       = sda_oe_q;
   assign reg_addr     = ptr_q;
   assign reg_wdata    = wdata_q;
   assign reg_write_en = we_q;
   assign reg_read_en  = re_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_serdesphy_i2c_slave.sv
// Testbench for serdesphy_i2c_slave: bit-banged I2C master, CSR register
// model, strobe scoreboard and a pointer-addressed memory reference model.
module tb_serdesphy_i2c_slave;
   localparam logic [6:0] DEV = 7'h42;
   localparam int Q = 5;  // quarter SCL period in clk cycles (SCL = clk/20)

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl_pin = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_line;
   logic       sda_oe, reg_write_en, reg_read_en, busy;
   logic [7:0] reg_addr, reg_wdata;
   logic [7:0] reg_rdata = 8'h00;

   assign sda_line = sda_m & ~sda_oe;

   serdesphy_i2c_slave #(.I2C_ADDR(DEV)) dut (
      .clk(clk), .rst(rst), .scl_in(scl_pin), .sda_in(sda_line),
      .sda_oe(sda_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_write_en(reg_write_en), .reg_read_en(reg_read_en),
      .reg_rdata(reg_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   // ---------------- CSR block model and strobe monitor ----------------
   logic [7:0]  csr_mem [256];
   logic [15:0] obs_wr_q [$];
   logic [7:0]  obs_rd_q [$];
   int          both_cnt = 0;
   int          oe_cnt = 0;

   always @(posedge clk) begin
      if (reg_write_en) csr_mem[reg_addr] <= reg_wdata;
      if (reg_read_en) reg_rdata <= csr_mem[reg_addr];
   end

   always @(negedge clk) begin
      if (reg_write_en) obs_wr_q.push_back({reg_addr, reg_wdata});
      if (reg_read_en) obs_rd_q.push_back(reg_addr);
      if (reg_write_en && reg_read_en) both_cnt++;
      if (sda_oe) oe_cnt++;
   end

   // ---------------- checking ----------------
   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model: pointer-addressed memory ----------------
   logic [7:0]  model_mem [256];
   logic [7:0]  model_ptr = 8'h00;
   logic [15:0] exp_wr_q [$];
   logic [7:0]  exp_rd_q [$];
   logic [7:0]  wbuf [4];
   logic [7:0]  rbuf [4];
   logic [7:0]  ebuf [4];

   task automatic model_write(input logic [6:0] a, input logic [7:0] p, input int nd);
      if (a == DEV) begin
         model_ptr = p;
         for (int i = 0; i < nd; i++) begin
            exp_wr_q.push_back({model_ptr, wbuf[i]});
            model_mem[model_ptr] = wbuf[i];
            model_ptr = model_ptr + 8'd1;
         end
      end
   endtask

   task automatic model_read(input logic [6:0] a, input int n);
      if (a == DEV) begin
         for (int i = 0; i < n; i++) begin
            ebuf[i] = model_mem[model_ptr];
            exp_rd_q.push_back(model_ptr);
            model_ptr = model_ptr + 8'd1;
         end
      end
   endtask

   task automatic sb_clear();
      obs_wr_q.delete(); obs_rd_q.delete(); exp_wr_q.delete(); exp_rd_q.delete();
   endtask

   task automatic sb_check(input string tag);
      chk({tag, "_nwr"}, 32'(obs_wr_q.size()), 32'(exp_wr_q.size()));
      for (int i = 0; i < exp_wr_q.size() && i < obs_wr_q.size(); i++)
         chk({tag, "_wr"}, 32'(obs_wr_q[i]), 32'(exp_wr_q[i]));
      chk({tag, "_nrd"}, 32'(obs_rd_q.size()), 32'(exp_rd_q.size()));
      for (int i = 0; i < exp_rd_q.size() && i < obs_rd_q.size(); i++)
         chk({tag, "_rd"}, 32'(obs_rd_q[i]), 32'(exp_rd_q[i]));
      sb_clear();
   endtask

   // ---------------- I2C master driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; tick(Q);
      scl_pin = 1'b1; tick(Q);
      sda_m = 1'b0; tick(Q);
      scl_pin = 1'b0; tick(Q);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; tick(Q);
      scl_pin = 1'b1; tick(Q);
      sda_m = 1'b1; tick(2 * Q);
   endtask

   task automatic send_bit(input logic b);
      sda_m = b; tick(Q);
      scl_pin = 1'b1; tick(2 * Q);
      scl_pin = 1'b0; tick(Q);
   endtask

   task automatic recv_bit(output logic b);
      sda_m = 1'b1; tick(Q);
      scl_pin = 1'b1; tick(Q);
      b = sda_line; tick(Q);
      scl_pin = 1'b0; tick(Q);
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      recv_bit(b);
      ack = ~b;
   endtask

   task automatic recv_byte(output logic [7:0] d, input logic ack);
      logic b;
      d = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         d[i] = b;
      end
      send_bit(~ack);
   endtask

   task automatic xfer_write(input logic [6:0] a, input logic [7:0] p, input int nd,
                             input logic do_stop, output int acks);
      logic ak;
      acks = 0;
      bus_start();
      send_byte({a, 1'b0}, ak); acks = acks + int'(ak);
      send_byte(p, ak);         acks = acks + int'(ak);
      for (int i = 0; i < nd; i++) begin
         send_byte(wbuf[i], ak);
         acks = acks + int'(ak);
      end
      if (do_stop) bus_stop();
   endtask

   task automatic xfer_read(input logic [6:0] a, input int n, output int acks);
      logic ak;
      bus_start();
      send_byte({a, 1'b1}, ak);
      acks = int'(ak);
      if (ak) begin
         for (int i = 0; i < n; i++) recv_byte(rbuf[i], (i < n - 1));
      end
      bus_stop();
   endtask

   // ---------------- directed write vectors ----------------
   typedef struct {
      logic [6:0]  addr;
      logic [7:0]  ptr;
      int          nd;
      logic [7:0]  d0;
      logic [7:0]  d1;
      int          exp_acks;
      int          exp_nwr;
      logic [15:0] exp_w0;
      logic [15:0] exp_w1;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int   acks;
      logic ak;
      logic b;
      logic [7:0] p0;

      vecs[0] = '{7'h42, 8'h04, 2, 8'h9A, 8'h3C, 4, 2, 16'h049A, 16'h053C};
      vecs[1] = '{7'h43, 8'h11, 0, 8'h00, 8'h00, 0, 0, 16'h0000, 16'h0000};
      vecs[2] = '{7'h42, 8'hFF, 2, 8'h01, 8'h02, 4, 2, 16'hFF01, 16'h0002};
      vecs[3] = '{7'h42, 8'h10, 1, 8'hC3, 8'h00, 3, 1, 16'h10C3, 16'h0000};
      vecs[4] = '{7'h00, 8'h55, 1, 8'h77, 8'h00, 0, 0, 16'h0000, 16'h0000};
      vecs[5] = '{7'h21, 8'h00, 1, 8'h66, 8'h00, 0, 0, 16'h0000, 16'h0000};

      for (int i = 0; i < 256; i++) begin
         csr_mem[i]   = 8'(i * 7 + 3);
         model_mem[i] = 8'(i * 7 + 3);
      end
      csr_mem[6] = 8'h5A; model_mem[6] = 8'h5A;
      csr_mem[7] = 8'h00; model_mem[7] = 8'h00;

      // ---- clock/reset ----
      rst = 1'b1; tick(5);
      rst = 1'b0; tick(4);
      chk("rst_sda_oe", 32'(sda_oe), 32'd0);
      chk("rst_reg_addr", 32'(reg_addr), 32'h00);
      chk("rst_reg_wdata", 32'(reg_wdata), 32'h00);
      chk("rst_write_en", 32'(reg_write_en), 32'd0);
      chk("rst_read_en", 32'(reg_read_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      // ---- table-driven write transactions ----
      for (int v = 0; v < 6; v++) begin
         wbuf[0] = vecs[v].d0;
         wbuf[1] = vecs[v].d1;
         oe_cnt = 0;
         sb_clear();
         xfer_write(vecs[v].addr, vecs[v].ptr, vecs[v].nd, 1'b1, acks);
         chk($sformatf("vec%0d_acks", v), 32'(acks), 32'(vecs[v].exp_acks));
         chk($sformatf("vec%0d_nwr", v), 32'(obs_wr_q.size()), 32'(vecs[v].exp_nwr));
         if (vecs[v].exp_nwr >= 1 && obs_wr_q.size() >= 1)
            chk($sformatf("vec%0d_wr0", v), 32'(obs_wr_q[0]), 32'(vecs[v].exp_w0));
         if (vecs[v].exp_nwr >= 2 && obs_wr_q.size() >= 2)
            chk($sformatf("vec%0d_wr1", v), 32'(obs_wr_q[1]), 32'(vecs[v].exp_w1));
         if (vecs[v].exp_acks == 0)
            chk($sformatf("vec%0d_oe_quiet", v), 32'(oe_cnt), 32'd0);
         chk($sformatf("vec%0d_nrd", v), 32'(obs_rd_q.size()), 32'd0);
         chk($sformatf("vec%0d_busy_end", v), 32'(busy), 32'd0);
         model_write(vecs[v].addr, vecs[v].ptr, vecs[v].nd);
         sb_clear();
      end

      // ---- read via repeated START ----
      xfer_write(DEV, 8'h06, 0, 1'b0, acks);
      chk("rd_setptr_acks", 32'(acks), 32'd2);
      xfer_read(DEV, 2, acks);
      chk("rd_addr_ack", 32'(acks), 32'd1);
      chk("rd_byte0", 32'(rbuf[0]), 32'h5A);
      chk("rd_byte1", 32'(rbuf[1]), 32'h00);
      chk("rd_nstrobes", 32'(obs_rd_q.size()), 32'd2);
      if (obs_rd_q.size() >= 2) begin
         chk("rd_strobe0", 32'(obs_rd_q[0]), 32'h06);
         chk("rd_strobe1", 32'(obs_rd_q[1]), 32'h07);
      end
      chk("rd_nwr", 32'(obs_wr_q.size()), 32'd0);
      chk("rd_ptr_after", 32'(reg_addr), 32'h08);
      model_write(DEV, 8'h06, 0);
      model_read(DEV, 2);
      sb_clear();

      // ---- START then STOP, no data ----
      p0 = reg_addr;
      bus_start();
      chk("ss_busy_high", 32'(busy), 32'd1);
      bus_stop();
      chk("ss_busy_low", 32'(busy), 32'd0);
      chk("ss_nstrobes", 32'(obs_wr_q.size() + obs_rd_q.size()), 32'd0);
      chk("ss_ptr_kept", 32'(reg_addr), 32'(model_ptr));
      chk("ss_ptr_kept_start", 32'(reg_addr), 32'(p0));
      sb_clear();

      // ---- reset in the middle of a data byte ----
      bus_start();
      send_byte({DEV, 1'b0}, ak);
      chk("mr_addr_ack", 32'(ak), 32'd1);
      send_byte(8'h20, ak);
      chk("mr_ptr_ack", 32'(ak), 32'd1);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      rst = 1'b1; tick(4);
      rst = 1'b0; tick(2);
      chk("mr_sda_oe", 32'(sda_oe), 32'd0);
      chk("mr_reg_addr", 32'(reg_addr), 32'h00);
      chk("mr_reg_wdata", 32'(reg_wdata), 32'h00);
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_strobes", 32'({reg_write_en, reg_read_en}), 32'd0);
      send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
      recv_bit(b);
      chk("mr_no_ack1", 32'(b), 32'd1);
      send_byte(8'hA5, ak);
      chk("mr_no_ack2", 32'(ak), 32'd0);
      chk("mr_nstrobes", 32'(obs_wr_q.size() + obs_rd_q.size()), 32'd0);
      sda_m = 1'b1; tick(Q);
      scl_pin = 1'b1; tick(2 * Q);
      model_ptr = 8'h00;
      sb_clear();

      // ---- randomized transactions against the reference model ----
      for (int t = 0; t < 24; t++) begin
         int kind, nd, n, exp_acks;
         logic [6:0] a;
         logic [7:0] p;
         kind = $urandom_range(0, 2);
         a = DEV;
         if ($urandom_range(0, 4) == 0) begin
            a = 7'($urandom_range(0, 127));
            if (a == DEV) a = a ^ 7'h01;
         end
         p = 8'($urandom);
         if (kind == 0) begin
            nd = $urandom_range(1, 3);
            for (int i = 0; i < nd; i++) wbuf[i] = 8'($urandom);
            model_write(a, p, nd);
            exp_acks = (a == DEV) ? nd + 2 : 0;
            xfer_write(a, p, nd, 1'b1, acks);
            chk($sformatf("rnd%0d_wacks", t), 32'(acks), 32'(exp_acks));
         end else begin
            n = $urandom_range(1, 3);
            if (kind == 1) begin
               model_write(DEV, p, 0);
               xfer_write(DEV, p, 0, 1'b0, acks);
               chk($sformatf("rnd%0d_packs", t), 32'(acks), 32'd2);
            end
            model_read(a, n);
            xfer_read(a, n, acks);
            chk($sformatf("rnd%0d_racks", t), 32'(acks), (a == DEV) ? 32'd1 : 32'd0);
            if (a == DEV) begin
               for (int i = 0; i < n; i++)
                  chk($sformatf("rnd%0d_rdata%0d", t, i), 32'(rbuf[i]), 32'(ebuf[i]));
            end
         end
         sb_check($sformatf("rnd%0d", t));
         chk($sformatf("rnd%0d_ptr", t), 32'(reg_addr), 32'(model_ptr));
      end

      chk("strobe_overlap", 32'(both_cnt), 32'd0);
      chk("final_busy", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serdesphy_i2c_slave.md
# serdesphy_i2c_slave

I²C target front-end for the SerDes PHY control plane. Decodes I²C bus transactions on the chip's SCL/SDA pins and drives the single-cycle register interface of `serdesphy_csr_registers` (`reg_addr`, `reg_wdata`, `reg_write_en`, `reg_read_en`, `reg_rdata`). The block holds an auto-incrementing register pointer. It supports multi-byte writes and reads, repeated START and address filtering, and runs entirely on the system clock using oversampled SCL/SDA.

## Interface
- `I2C_ADDR`, default 7'h42: 7-bit target address.
- `clk` in 1: system clock. One clock; all logic sits on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `scl_in` in 1: raw SCL pin level, asynchronous.
- `sda_in` in 1: raw SDA pin level, asynchronous.
- `sda_oe` out 1: 1 pulls SDA low; 0 releases it. Open-drain; the pad is external.
- `reg_addr` out 8: register pointer, driven straight from the pointer register.
- `reg_wdata` out 8: write data byte.
- `reg_write_en` out 1: one-cycle write strobe.
- `reg_read_en` out 1: one-cycle read strobe.
- `reg_rdata` in 8: read data, valid on the cycle after `reg_read_en`. The CSR block registers it.
- `busy` out 1: high from a detected START to a detected STOP.

## Operation
- **Input conditioning.** `scl_in` and `sda_in` each pass through a 2-flop synchronizer and then a history flop. All sync and history flops reset to 1.
  - SCL rise or fall event: history differs from the synced value.
  - START: synced SDA falls while synced SCL is 1.
  - STOP: synced SDA rises while synced SCL is 1.
  - START and STOP take priority over bit processing in the same cycle.
- **Bit handling.** Bits are sampled on the SCL rise event. SDA output changes on the SCL fall event. A 3-bit counter and 8-bit shift register are used, MSB first.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- **Global transitions:**
  - START from any state → ADDR, `busy`=1, bit counter cleared. This covers repeated START.
  - STOP from any state → IDLE, `sda_oe`=0, `busy`=0.
  - The pointer is kept across START and STOP; only `rst` clears it.
- **ADDR, after 8 bits:**
  - Address does not match → IGNORE. No ACK is driven; wait for START or STOP.
  - Address matches → ADDR_ACK, with `sda_oe`=1 for the ACK bit.
  - If R/W=1, also issue the read prefetch (see below).
- **After ADDR_ACK:** R/W=0 → PTR; R/W=1 → RDATA.
- **PTR:** after 8 bits, load the pointer with the received byte, then ACK (PTR_ACK) → WDATA.
- **WDATA:**
  - After 8 bits, pulse `reg_write_en` with `reg_wdata`=byte and `reg_addr`=pointer.
  - ACK (WDATA_ACK), then return to WDATA for the next byte.
- **Read prefetch:**
  - Pulse `reg_read_en` with `reg_addr`=pointer.
  - Capture `reg_rdata` into the TX shift register two cycles after the pulse.
  - Increment the pointer in that same cycle.
- **RDATA:** drive `sda_oe` = ~bit on each SCL fall event, MSB first. After the 8th bit's fall, release SDA → RDATA_ACK.
- **RDATA_ACK, on the SCL rise event:**
  - SDA=0 (master ACK): issue a prefetch → RDATA.
  - SDA=1 (master NACK): → IGNORE; SDA stays released.
- **Pointer arithmetic:** 8-bit, wraps 0xFF → 0x00. No CSR address range check is done here.
- **Reset mid-operation:**
  - State → IDLE.
  - Every output takes its reset value.
  - Partial bytes are discarded.
  - All SCL/SDA activity is ignored until the next START.

## Timing
- **Reset values:**
  - `sda_oe`=0, `reg_addr`=8'h00, `reg_wdata`=8'h00.
  - `reg_write_en`=0, `reg_read_en`=0, `busy`=0.
  - State IDLE, pointer 8'h00.
- **Event latency:** an SCL or SDA pin edge is detected 3 clk cycles later (2 sync + history).
- **Write strobe:** let the 8th data-bit SCL rise event be at cycle R.
  - `reg_write_en`=1 at R+1 only.
  - Pointer = pointer+1 at R+2.
  - `reg_wdata` holds until the next write.
- **ACK drive:**
  - `sda_oe` goes to 1 at F+1, where F is the SCL fall event after the 8th bit.
  - It returns to 0 at F'+1, where F' is the next fall event. In read mode it is instead loaded with the first data bit at F'+1.
- **Read:**
  - Prefetch strobe `reg_read_en`=1 at R+1.
  - TX capture and pointer increment at R+3.
  - R is the address 8th-bit rise event, or the master-ACK rise event.
- **Clock ratio:** requires f(clk) ≥ 16 × f(SCL), which guarantees the TX capture completes before the next SCL fall. No clock stretching.
- **Strobe exclusivity:** `reg_write_en` and `reg_read_en` are never high in the same cycle.

## Test plan
- **Multi-byte write.** START, 0x84, 0x04, 0x9A, 0x3C, STOP.
  - ACK on all 4 bytes.
  - Write strobes: (addr 04, data 9A), then (addr 05, data 3C).
  - `busy` falls after STOP.
- **Read via repeated START.** Write pointer 0x06, repeated START, 0x85, read 2 bytes (ACK then NACK). CSR model returns 0x5A and 0x00.
  - `reg_read_en` at addr 06 and 07.
  - SDA carries 0x5A then 0x00.
  - No third read strobe.
- **Address mismatch.** START, 0x86 (addr 0x43), 0x11, STOP.
  - `sda_oe` stays 0 throughout.
  - No write or read strobes.
- **Pointer wrap.** Write pointer 0xFF, data 0x01, 0x02 → strobes at addr FF then addr 00.
- **Reset mid-write.** Assert `rst` after 4 bits of a data byte.
  - All outputs go to reset values.
  - Following SCL pulses without a START produce no ACK and no strobes.
- **START and STOP without data.** START then STOP → `busy` pulses; no strobes; pointer unchanged.
